fetch_unit: RTL

Instruction fetch stage of the RISC-V core: owns the program counter, issues word reads to instruction memory over a valid/ready request channel, and hands each fetched instruction plus its PC to decode over a valid/ready channel. It is the consuming end of the branch evaluation path. Execute drives `redirect_valid`/`redirect_target` when a branch or jump is taken, and this block squashes in-flight work and refetches from the target. One outstanding memory request at a time.

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 112 +++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/response, decode hand-off,
// branch redirect input and the sticky error flag.
interface fetch_unit_if;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        error;

   modport master (
      output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, error,
      input  mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
             redirect_valid, redirect_target
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, error,
      output mem_req_ready, mem_resp_valid, mem_resp_data, inst_ready,
             redirect_valid, redirect_target
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one memory read in flight and
// refetches from the branch target on redirect, squashing stale responses.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   fetch_unit_if.master  bus
);

   typedef enum logic [2:0] {
      START = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      ERROR = 3'd4
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic        discard_reg, discard_next;
   logic [31:0] inst_data_reg, inst_data_next;
   logic [31:0] inst_pc_reg, inst_pc_next;

   logic redirect_ok;
   logic redirect_bad;
   logic req_fire;

   assign redirect_ok  = bus.redirect_valid && (bus.redirect_target[1:0] == 2'b00);
   assign redirect_bad = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
   assign req_fire     = (state_reg == REQ) && bus.mem_req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= START;
         pc_reg        <= RESET_PC;
         discard_reg   <= 1'b0;
         inst_data_reg <= 32'h0;
         inst_pc_reg   <= 32'h0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         discard_reg   <= discard_next;
         inst_data_reg <= inst_data_next;
         inst_pc_reg   <= inst_pc_next;
      end
   end

   // A misaligned redirect outranks everything; an aligned one outranks all
   // handshakes but never stops an already-accepted request from being waited on.
   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      discard_next   = discard_reg;
      inst_data_next = inst_data_reg;
      inst_pc_next   = inst_pc_reg;

      if (state_reg != ERROR && redirect_bad) begin
         state_next = ERROR;
      end else begin
         case (state_reg)
            START: begin
               state_next = REQ;
               if (redirect_ok) pc_next = bus.redirect_target;
            end
            REQ: begin
               if (redirect_ok) pc_next = bus.redirect_target;
               if (req_fire) begin
                  state_next   = WAIT;
                  discard_next = redirect_ok;
               end
            end
            WAIT: begin
               if (redirect_ok) begin
                  pc_next      = bus.redirect_target;
                  discard_next = 1'b1;
                  if (bus.mem_resp_valid) state_next = REQ;
               end else if (bus.mem_resp_valid) begin
                  if (discard_reg) begin
                     state_next = REQ;
                  end else begin
                     inst_data_next = bus.mem_resp_data;
                     inst_pc_next   = pc_reg;
                     state_next     = HOLD;
                  end
               end
            end
            HOLD: begin
               if (redirect_ok) begin
                  pc_next    = bus.redirect_target;
                  state_next = REQ;
               end else if (bus.inst_ready) begin
                  pc_next    = pc_reg + 32'd4;
                  state_next = REQ;
               end
            end
            default: state_next = ERROR;
         endcase
      end
   end

   always_comb begin
      bus.mem_req_valid = (state_reg == REQ);
      bus.inst_valid    = (state_reg == HOLD);
      bus.error         = (state_reg == ERROR);
   end

   assign bus.mem_req_addr = pc_reg;
   assign bus.inst_data    = inst_data_reg;
   assign bus.inst_pc      = inst_pc_reg;

endmodule
